// File: rtl/adc_result_reader.sv
`default_nettype none
// ============================================================================
//  Module   : adc_result_reader
//  Purpose  : Captures SAR conversion results on the rising edge of the
//             conversion-done strobe and buffers them in a first-word-fall-
//             through FIFO. Results that arrive while the FIFO is full and
//             not being read are dropped and counted.
//  Revision : 1.0  initial release
// ============================================================================
module adc_result_reader #(
  parameter int RESULT_BITS = 12,
  parameter int FIFO_DEPTH  = 4    // power of two, 2..16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          conv_finished_strobe_in,
  input  logic [RESULT_BITS-1:0]        result_in,
  input  logic                          rd_ready_in,
  input  logic                          clear_overflow_in,
  output logic [RESULT_BITS-1:0]        data_out,
  output logic                          data_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   level_out,
  output logic                          overflow_out,
  output logic [7:0]                    drop_count_out
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int LVL_BITS = PTR_BITS + 1;
  localparam logic [LVL_BITS-1:0] LEVEL_FULL = LVL_BITS'(FIFO_DEPTH);
  localparam logic [7:0]          DROP_MAX   = 8'hFF;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [RESULT_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]    wr_ptr;
  logic [PTR_BITS-1:0]    rd_ptr;
  logic [LVL_BITS-1:0]    level;
  logic                   strobe_d;
  logic                   overflow;
  logic [7:0]             drop_count;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic capture;   // rising edge of the conversion-done strobe
  logic full;
  logic pop;
  logic push_ok;   // capture that is written into storage
  logic drop;      // capture that is discarded

  // Edge detect, FIFO handshake and drop decision
  always_comb begin
    capture = conv_finished_strobe_in & ~strobe_d;
    full    = (level == LEVEL_FULL);
    pop     = data_valid_out & rd_ready_in;
    // When full, a same-cycle pop frees the head slot, so the push still fits.
    push_ok = capture & (~full | pop);
    drop    = capture & full & ~pop;
  end

  // Strobe delay register; cleared by reset so a strobe already high at
  // deassertion is seen as a fresh edge on the first clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_d <= 1'b0;
    end else begin
      strobe_d <= conv_finished_strobe_in;
    end
  end

  // Result storage; contents are don't-care until covered by the level count
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= result_in;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_BITS'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_BITS'(1);
        2'b01:   level <= level - LVL_BITS'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow_in) begin
      overflow <= 1'b0;
    end
  end

  // Saturating drop counter; a clear coinciding with a drop restarts at one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= 8'd0;
    end else if (clear_overflow_in) begin
      drop_count <= drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_count != DROP_MAX)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // Outputs; the head word is gated so data_out reads zero whenever empty,
  // including immediately on reset.
  always_comb begin
    data_valid_out = (level != '0);
    data_out       = data_valid_out ? mem[rd_ptr] : '0;
    level_out      = level;
    overflow_out   = overflow;
    drop_count_out = drop_count;
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_result_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_result_reader
//  Purpose  : Directed self-checking bench for adc_result_reader
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_result_reader;

  localparam int RESULT_BITS = 12;
  localparam int FIFO_DEPTH  = 4;

  logic                        clk;
  logic                        rst;
  logic                        strobe;
  logic [RESULT_BITS-1:0]      result;
  logic                        rd_ready;
  logic                        clear_ovf;
  logic [RESULT_BITS-1:0]      data;
  logic                        valid;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic                        overflow;
  logic [7:0]                  drops;

  int total;
  int bad;

  adc_result_reader #(
    .RESULT_BITS (RESULT_BITS),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .conv_finished_strobe_in (strobe),
    .result_in               (result),
    .rd_ready_in             (rd_ready),
    .clear_overflow_in       (clear_ovf),
    .data_out                (data),
    .data_valid_out          (valid),
    .level_out               (level),
    .overflow_out            (overflow),
    .drop_count_out          (drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Single-cycle strobe carrying value v
  task automatic pulse(input logic [RESULT_BITS-1:0] v);
    strobe = 1'b1;
    result = v;
    cycle();
    strobe = 1'b0;
    cycle();
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    cycle();
    rd_ready = 1'b0;
  endtask

  logic [RESULT_BITS-1:0] seq6 [6];

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    strobe    = 1'b0;
    result    = '0;
    rd_ready  = 1'b0;
    clear_ovf = 1'b0;
    seq6[0] = 12'd2048; seq6[1] = 12'd806; seq6[2] = 12'd13;
    seq6[3] = 12'd489;  seq6[4] = 12'd4095; seq6[5] = 12'd0;

    // Reset state
    cycle();
    cycle();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_drops", 32'(drops), 0);
    chk("rst_data",  32'(data), 0);
    rst = 1'b0;
    cycle();

    // Six single-cycle strobes, each read back with a one-cycle ready pulse
    for (int i = 0; i < 6; i++) begin
      strobe = 1'b1;
      result = seq6[i];
      cycle();
      strobe = 1'b0;
      chk("seq_valid", 32'(valid), 1);
      chk("seq_data",  32'(data), 32'(seq6[i]));
      chk("seq_level", 32'(level), 1);
      pop_one();
      chk("seq_level_after_pop", 32'(level), 0);
      chk("seq_valid_after_pop", 32'(valid), 0);
    end

    // Strobe held five cycles counts once
    strobe = 1'b1;
    result = 12'd806;
    repeat (5) cycle();
    strobe = 1'b0;
    cycle();
    chk("held_level", 32'(level), 1);
    chk("held_data",  32'(data), 806);
    pop_one();
    chk("held_level_after_pop", 32'(level), 0);

    // Ready while empty has no effect
    rd_ready = 1'b1;
    cycle();
    cycle();
    rd_ready = 1'b0;
    chk("empty_rd_level", 32'(level), 0);
    chk("empty_rd_valid", 32'(valid), 0);

    // Overflow: six pushes into a depth-4 FIFO with no reads
    for (int i = 1; i <= 6; i++) pulse(RESULT_BITS'(i));
    chk("ovf_level", 32'(level), 4);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_drops", 32'(drops), 2);
    cycle();
    chk("ovf_head_stable", 32'(data), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain_valid", 32'(valid), 1);
      chk("ovf_drain_data",  32'(data), 32'(k));
      pop_one();
    end
    chk("ovf_drained_level", 32'(level), 0);
    chk("ovf_flag_sticky",   32'(overflow), 1);

    // Clear overflow
    clear_ovf = 1'b1;
    cycle();
    clear_ovf = 1'b0;
    chk("clr_flag",  32'(overflow), 0);
    chk("clr_drops", 32'(drops), 0);

    // Full FIFO with push and pop in the same cycle
    pulse(12'd10); pulse(12'd11); pulse(12'd12); pulse(12'd13);
    chk("full_level", 32'(level), 4);
    strobe   = 1'b1;
    result   = 12'd99;
    rd_ready = 1'b1;
    cycle();
    strobe   = 1'b0;
    rd_ready = 1'b0;
    chk("full_pp_level", 32'(level), 4);
    chk("full_pp_flag",  32'(overflow), 0);
    chk("full_pp_drops", 32'(drops), 0);
    chk("full_pp_head",  32'(data), 11);
    pop_one(); chk("full_pp_d12", 32'(data), 12);
    pop_one(); chk("full_pp_d13", 32'(data), 13);
    pop_one(); chk("full_pp_d99", 32'(data), 99);
    pop_one(); chk("full_pp_empty", 32'(valid), 0);

    // 300 strobes without reads: counter saturates at 255
    for (int i = 0; i < 300; i++) pulse(RESULT_BITS'(100 + i));
    chk("sat_drops", 32'(drops), 255);
    chk("sat_flag",  32'(overflow), 1);
    chk("sat_level", 32'(level), 4);
    chk("sat_head",  32'(data), 100);
    // Clear coinciding with a drop
    clear_ovf = 1'b1;
    strobe    = 1'b1;
    result    = 12'd7;
    cycle();
    clear_ovf = 1'b0;
    strobe    = 1'b0;
    chk("clr_drop_flag",  32'(overflow), 1);
    chk("clr_drop_drops", 32'(drops), 1);
    chk("clr_drop_level", 32'(level), 4);

    // Asynchronous reset between edges with level 3
    pop_one();
    chk("pre_arst_level", 32'(level), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_data",  32'(data), 0);
    chk("arst_flag",  32'(overflow), 0);
    chk("arst_drops", 32'(drops), 0);
    #1;
    rst = 1'b0;
    strobe = 1'b1;
    result = 12'd13;
    cycle();
    strobe = 1'b0;
    chk("post_arst_data",  32'(data), 13);
    chk("post_arst_level", 32'(level), 1);
    cycle();

    // Strobe already high when reset deasserts counts as one capture
    rst    = 1'b1;
    strobe = 1'b1;
    result = 12'd55;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_strobe_level", 32'(level), 1);
    chk("rst_strobe_data",  32'(data), 55);
    cycle();
    chk("rst_strobe_hold_level", 32'(level), 1);
    strobe = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
